// File: rtl/core_ctrl_pkg.sv
// Shared types and default sizing for the scratch-core instruction sequencer.
package core_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SETUP,
        EXECUTE,
        WRITEBACK,
        HALTED,
        FAULT
    } ctrl_state_t;

    localparam int unsigned DEF_CNT_WIDTH      = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned DEF_TO_WIDTH       = 8;

endpackage

// File: rtl/ctrl_timeout_counter.sv
// Wait-cycle counter for handshake phases; expired flags that the limit has been reached.
module ctrl_timeout_counter #(
    parameter int unsigned LIMIT = 255,
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == WIDTH'(LIMIT));

endmodule

// File: rtl/core_state_sequencer.sv
// Instruction-cycle FSM: FETCH/DECODE/SETUP/EXECUTE/WRITEBACK with halt, fault and perf counters.
// Optional single-step input stepMode is present when CORE_SINGLE_STEP_EN is defined.
module core_state_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TO_WIDTH       = DEF_TO_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 haltReq,
    input  logic                 fetchAck,
    input  logic                 execDone,
`ifdef CORE_SINGLE_STEP_EN
    input  logic                 stepMode,
`endif
    output logic                 fetchReq,
    output logic                 fetchState,
    output logic                 decodeState,
    output logic                 setupState,
    output logic                 executeState,
    output logic                 writebackState,
    output logic                 idle,
    output logic                 halted,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] cycleCount,
    output logic [CNT_WIDTH-1:0] retiredCount
);

    ctrl_state_t          state_q, state_d;
    logic                 halt_pend_q, halt_pend_d;
    logic                 to_clear, to_enable, to_expired;
    logic                 step_en;
    logic [CNT_WIDTH-1:0] cycle_q, retired_q;
    logic                 fetch_q, decode_q, setup_q, execute_q, writeback_q;
    logic                 idle_q, halted_q, fault_q;

`ifdef CORE_SINGLE_STEP_EN
    assign step_en = stepMode;
`else
    assign step_en = 1'b0;
`endif

    ctrl_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TO_WIDTH)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (to_expired)
    );

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        unique case (state_q)
            IDLE:      if (run) state_d = FETCH;
            FETCH: begin
                if (fetchAck)        state_d = DECODE;
                else if (to_expired) state_d = FAULT;
            end
            DECODE:    state_d = SETUP;
            SETUP:     state_d = EXECUTE;
            EXECUTE: begin
                if (execDone)        state_d = WRITEBACK;
                else if (to_expired) state_d = FAULT;
            end
            WRITEBACK: begin
                if (halt_pend_q || haltReq || step_en) state_d = HALTED;
                else                                   state_d = FETCH;
            end
            HALTED:    if (run && !haltReq) state_d = FETCH;
            FAULT:     state_d = FAULT;
            default:   state_d = IDLE;
        endcase

        // A pending halt is only honoured at WRITEBACK, so it is consumed on entry to HALTED.
        if (state_d == HALTED) begin
            halt_pend_d = 1'b0;
        end else if (haltReq && (state_q inside {FETCH, DECODE, SETUP, EXECUTE})) begin
            halt_pend_d = 1'b1;
        end

        to_enable = ((state_q == FETCH) && !fetchAck) || ((state_q == EXECUTE) && !execDone);
        to_clear  = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            halt_pend_q <= 1'b0;
            cycle_q     <= '0;
            retired_q   <= '0;
            fetch_q     <= 1'b0;
            decode_q    <= 1'b0;
            setup_q     <= 1'b0;
            execute_q   <= 1'b0;
            writeback_q <= 1'b0;
            idle_q      <= 1'b1;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            if (!(state_q inside {IDLE, HALTED, FAULT})) begin
                cycle_q <= cycle_q + CNT_WIDTH'(1);
            end
            if (state_q == WRITEBACK) begin
                retired_q <= retired_q + CNT_WIDTH'(1);
            end
            // Strobes are loaded from the next-state decode so they track state_q exactly.
            fetch_q     <= (state_d == FETCH);
            decode_q    <= (state_d == DECODE);
            setup_q     <= (state_d == SETUP);
            execute_q   <= (state_d == EXECUTE);
            writeback_q <= (state_d == WRITEBACK);
            idle_q      <= (state_d == IDLE);
            halted_q    <= (state_d == HALTED);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign fetchReq       = fetch_q;
    assign fetchState     = fetch_q;
    assign decodeState    = decode_q;
    assign setupState     = setup_q;
    assign executeState   = execute_q;
    assign writebackState = writeback_q;
    assign idle           = idle_q;
    assign halted         = halted_q;
    assign fault          = fault_q;
    assign cycleCount     = cycle_q;
    assign retiredCount   = retired_q;

endmodule
